// File: rtl/reduce_sel_arbiter.sv
// Round-robin arbiter sharing the reduction-mux select and toggle-bank clear among NREQ requesters.
// Optional hold timeout with per-requester re-arm: define REDUCE_SEL_ARB_TIMEOUT_EN.
module reduce_sel_arbiter #(
  parameter int NREQ     = 4,
  parameter int RES_W    = 20,
  parameter int SETTLE   = 3,
  parameter int HOLD_MAX = 8
) (
  input  logic               CLK,
  input  logic               CLR,
  input  logic [NREQ-1:0]    req,
  input  logic [2*NREQ-1:0]  req_mode,
  output logic [NREQ-1:0]    gnt,
  output logic [1:0]         sel,
  output logic               bank_clr_n,
  input  logic [RES_W-1:0]   res_in,
  output logic [RES_W-1:0]   res_out,
  output logic               res_valid,
  output logic               busy
);

  localparam int IW   = (NREQ > 2) ? $clog2(NREQ) : 1;
  localparam int CMAX = (SETTLE > HOLD_MAX) ? SETTLE : HOLD_MAX;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_HOLD, ST_CLEAR} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [IW-1:0]    ptr, ptr_nx, win, win_nx;
  logic [NREQ-1:0]  gnt_nx;
  logic [1:0]       sel_nx;
  logic             bclr_nx, rv_nx, busy_nx, to_idle;
  logic [RES_W-1:0] res_nx;
  logic [NREQ-1:0]  req_eff;
  logic             found;
  logic [IW-1:0]    widx, cand;
  logic [1:0]       wmode;

`ifdef REDUCE_SEL_ARB_TIMEOUT_EN
  logic [NREQ-1:0]  arm, arm_nx;
  assign req_eff = req & arm;
`else
  assign req_eff = req;
`endif

  // Scan ptr+1, ptr+2, ... so the previous winner is considered last.
  always_comb begin
    found = 1'b0;
    widx  = '0;
    cand  = '0;
    wmode = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IW'((32'(ptr) + k) % NREQ);
      if (!found && req_eff[cand]) begin
        found = 1'b1;
        widx  = cand;
      end
    end
    for (int unsigned i = 0; i < NREQ; i++)
      if (IW'(i) == widx) wmode = req_mode[2*i +: 2];
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ptr_nx   = ptr;
    win_nx   = win;
    gnt_nx   = gnt;
    sel_nx   = sel;
    bclr_nx  = 1'b1;
    res_nx   = res_out;
    rv_nx    = 1'b0;
    to_idle  = 1'b0;
`ifdef REDUCE_SEL_ARB_TIMEOUT_EN
    arm_nx   = arm | ~req;
`endif
    case (state)
      ST_IDLE: begin
        gnt_nx = '0;
        sel_nx = 2'b11;
        if (found) begin
          gnt_nx[widx] = 1'b1;
          win_nx       = widx;
          if (wmode == 2'b11) begin
            bclr_nx  = 1'b0;
            cnt_nx   = CW'(1);
            state_nx = ST_CLEAR;
          end else begin
            sel_nx   = wmode;
            cnt_nx   = CW'(SETTLE - 1);
            state_nx = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (!req[win]) to_idle = 1'b1;
        else if (cnt == '0) begin
          res_nx   = res_in;
          rv_nx    = 1'b1;
          state_nx = ST_SAMPLE;
        end else cnt_nx = cnt - CW'(1);
      end
      ST_SAMPLE: begin
        state_nx = ST_HOLD;
`ifdef REDUCE_SEL_ARB_TIMEOUT_EN
        cnt_nx   = CW'(HOLD_MAX - 1);
`endif
      end
      ST_HOLD: begin
        if (!req[win]) to_idle = 1'b1;
`ifdef REDUCE_SEL_ARB_TIMEOUT_EN
        else if (cnt == '0) begin
          to_idle     = 1'b1;
          arm_nx[win] = 1'b0;
        end else cnt_nx = cnt - CW'(1);
`endif
      end
      ST_CLEAR: begin
        if (cnt != '0) begin
          bclr_nx = 1'b0;
          cnt_nx  = cnt - CW'(1);
        end else to_idle = 1'b1;
      end
      default: to_idle = 1'b1;
    endcase
    if (to_idle) begin
      state_nx = ST_IDLE;
      gnt_nx   = '0;
      sel_nx   = 2'b11;
      ptr_nx   = win;
    end
    busy_nx = (state_nx != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      ptr        <= IW'(NREQ - 1);
      win        <= '0;
      gnt        <= '0;
      sel        <= 2'b11;
      bank_clr_n <= 1'b0;
      res_out    <= '0;
      res_valid  <= 1'b0;
      busy       <= 1'b0;
`ifdef REDUCE_SEL_ARB_TIMEOUT_EN
      arm        <= '1;
`endif
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      ptr        <= ptr_nx;
      win        <= win_nx;
      gnt        <= gnt_nx;
      sel        <= sel_nx;
      bank_clr_n <= bclr_nx;
      res_out    <= res_nx;
      res_valid  <= rv_nx;
      busy       <= busy_nx;
`ifdef REDUCE_SEL_ARB_TIMEOUT_EN
      arm        <= arm_nx;
`endif
    end
  end

endmodule
